// File: rtl/comparador_serial_izq_der_if.sv
// Handshake/result bundle for the serial MSB-first magnitude comparator.
// The consumer/driver side uses master; the comparator uses slave.
interface comparador_serial_izq_der_if #(
   parameter int N = 8
);
   logic                       start;
   logic [N-1:0]               A;
   logic [N-1:0]               B;
   logic                       ready;
   logic                       valid;
   logic                       ack;
   logic                       P;
   logic                       Q;
   logic                       gt;
   logic                       lt;
   logic                       eq;
   logic [$clog2(N+1)-1:0]     bits_used;

   modport master (
      output start, A, B, ack,
      input  ready, valid, P, Q, gt, lt, eq, bits_used
   );

   modport slave (
      input  start, A, B, ack,
      output ready, valid, P, Q, gt, lt, eq, bits_used
   );
endinterface

// File: rtl/comparador_serial_izq_der.sv
// Unsigned A vs B comparison, one bit per clock from the MSB, using the
// P/Q encoding of the left-to-right comparator network (10 = A>B, 01 = A<B).
module comparador_serial_izq_der #(
   parameter int N          = 8,
   parameter bit EARLY_STOP = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   comparador_serial_izq_der_if.slave    bus
);
   localparam int BW       = $clog2(N + 1);
   localparam int IW       = (N > 1) ? $clog2(N) : 1;
   localparam int IDX_INIT = (N > 1) ? N - 2 : 0;

   typedef enum logic [1:0] {IDLE, INIT, SCAN, DONE} state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    a_q, a_d;
   logic [N-1:0]    b_q, b_d;
   logic            p_q, p_d;
   logic            q_q, q_d;
   logic [BW-1:0]   bits_q, bits_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            ready_q, ready_d;
   logic            valid_q, valid_d;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      p_d     = p_q;
      q_d     = q_q;
      bits_d  = bits_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d     = bus.A;
               b_d     = bus.B;
               p_d     = 1'b0;
               q_d     = 1'b0;
               bits_d  = '0;
               state_d = INIT;
            end
         end
         INIT: begin
            p_d    = a_q[N-1] & ~b_q[N-1];
            q_d    = ~a_q[N-1] & b_q[N-1];
            bits_d = BW'(1);
            idx_d  = IW'(IDX_INIT);
            if (N == 1 || (EARLY_STOP && (p_d | q_d)))
               state_d = DONE;
            else
               state_d = SCAN;
         end
         SCAN: begin
            // A decided PQ is absorbing; only an undecided state looks at the bit.
            if (!(p_q | q_q)) begin
               p_d = a_q[idx_q] & ~b_q[idx_q];
               q_d = ~a_q[idx_q] & b_q[idx_q];
            end
            bits_d = bits_q + BW'(1);
            if (idx_q == '0 || (EARLY_STOP && (p_d | q_d)))
               state_d = DONE;
            else
               idx_d = idx_q - IW'(1);
         end
         DONE: begin
            if (bus.ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
      valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         p_q     <= 1'b0;
         q_q     <= 1'b0;
         bits_q  <= '0;
         idx_q   <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         p_q     <= p_d;
         q_q     <= q_d;
         bits_q  <= bits_d;
         idx_q   <= idx_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
      end
   end

   assign bus.ready     = ready_q;
   assign bus.valid     = valid_q;
   assign bus.P         = p_q;
   assign bus.Q         = q_q;
   assign bus.gt        = valid_q & p_q;
   assign bus.lt        = valid_q & q_q;
   assign bus.eq        = valid_q & ~p_q & ~q_q;
   assign bus.bits_used = bits_q;
endmodule

// File: tb/tb_comparador_serial_izq_der.sv
// Drives four comparators (N=8/N=4, each with and without early stop) with
// shared stimulus and checks them against an arithmetic reference model.
module tb_comparador_serial_izq_der;
   logic       clk = 1'b0;
   logic       rst;
   logic       st;
   logic [3:0] ack;
   logic [7:0] a8, b8;
   logic [3:0] a4, b4;
   int         nchk = 0;
   int         nfail = 0;

   always #5 clk = ~clk;

   comparador_serial_izq_der_if #(.N(8)) i0 ();
   comparador_serial_izq_der_if #(.N(8)) i1 ();
   comparador_serial_izq_der_if #(.N(4)) i2 ();
   comparador_serial_izq_der_if #(.N(4)) i3 ();

   assign i0.start = st; assign i0.A = a8; assign i0.B = b8; assign i0.ack = ack[0];
   assign i1.start = st; assign i1.A = a8; assign i1.B = b8; assign i1.ack = ack[1];
   assign i2.start = st; assign i2.A = a4; assign i2.B = b4; assign i2.ack = ack[2];
   assign i3.start = st; assign i3.A = a4; assign i3.B = b4; assign i3.ack = ack[3];

   comparador_serial_izq_der #(.N(8), .EARLY_STOP(1'b1)) d0 (.clk(clk), .rst(rst), .bus(i0));
   comparador_serial_izq_der #(.N(8), .EARLY_STOP(1'b0)) d1 (.clk(clk), .rst(rst), .bus(i1));
   comparador_serial_izq_der #(.N(4), .EARLY_STOP(1'b1)) d2 (.clk(clk), .rst(rst), .bus(i2));
   comparador_serial_izq_der #(.N(4), .EARLY_STOP(1'b0)) d3 (.clk(clk), .rst(rst), .bus(i3));

   logic [3:0] rdy, vld, gtv, ltv, eqv, pv, qv;
   logic [7:0] bu [4];
   assign rdy = {i3.ready, i2.ready, i1.ready, i0.ready};
   assign vld = {i3.valid, i2.valid, i1.valid, i0.valid};
   assign gtv = {i3.gt, i2.gt, i1.gt, i0.gt};
   assign ltv = {i3.lt, i2.lt, i1.lt, i0.lt};
   assign eqv = {i3.eq, i2.eq, i1.eq, i0.eq};
   assign pv  = {i3.P, i2.P, i1.P, i0.P};
   assign qv  = {i3.Q, i2.Q, i1.Q, i0.Q};
   assign bu[0] = 8'(i0.bits_used);
   assign bu[1] = 8'(i1.bits_used);
   assign bu[2] = 8'(i2.bits_used);
   assign bu[3] = 8'(i3.bits_used);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: plain unsigned compare; scan length is the distance to the
   // first differing bit from the MSB when stopping early, else the width.
   function automatic void model(input int a, input int b, input int n, input bit es,
                                 output int g, output int l, output int e, output int nb);
      bit found = 1'b0;
      g = (a > b) ? 1 : 0;
      l = (a < b) ? 1 : 0;
      e = (a == b) ? 1 : 0;
      nb = n;
      if (es)
         for (int i = n - 1; i >= 0; i--)
            if (!found && (((a >> i) & 1) != ((b >> i) & 1))) begin
               found = 1'b1;
               nb = n - i;
            end
   endfunction

   function automatic logic [31:0] snap(input int k);
      return {18'd0, vld[k], gtv[k], ltv[k], eqv[k], pv[k], qv[k], bu[k]};
   endfunction

   task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c,
                      input logic [3:0] d, input int hold, input int chg,
                      input logic [7:0] a2, input int pulse);
      int eg[4], el[4], ee[4], eb[4], lat[4];
      bit seen[4], acked[4], fin[4];
      logic [31:0] sv[4];
      int cyc;
      for (int k = 0; k < 4; k++) begin
         if (k < 2) model(int'(a), int'(b), 8, (k == 0), eg[k], el[k], ee[k], eb[k]);
         else       model(int'(c), int'(d), 4, (k == 2), eg[k], el[k], ee[k], eb[k]);
         seen[k] = 0; acked[k] = 0; fin[k] = 0; lat[k] = 0; sv[k] = '0;
      end
      @(negedge clk);
      chk("ready_before_start", 32'(rdy), 32'hF);
      a8 = a; b8 = b; a4 = c; b4 = d; st = 1'b1;
      @(negedge clk);
      st = 1'b0;
      cyc = 0;
      while (!(fin[0] && fin[1] && fin[2] && fin[3]) && cyc < 40) begin
         @(negedge clk);
         cyc++;
         st = (cyc == pulse);
         if (cyc == chg) begin a8 = a2; a4 = a2[3:0]; end
         for (int k = 0; k < 4; k++) begin
            if (!fin[k]) begin
               chk("pq_never_11", 32'(pv[k] & qv[k]), 32'd0);
               if (acked[k]) begin
                  ack[k] = 1'b0;
                  chk("ready_after_ack", 32'(rdy[k]), 32'd1);
                  chk("valid_after_ack", 32'(vld[k]), 32'd0);
                  fin[k] = 1;
               end else if (!seen[k]) begin
                  if (vld[k]) begin
                     seen[k] = 1;
                     lat[k] = cyc;
                     chk("latency", 32'(cyc), 32'(eb[k]));
                     chk("gt", 32'(gtv[k]), 32'(eg[k]));
                     chk("lt", 32'(ltv[k]), 32'(el[k]));
                     chk("eq", 32'(eqv[k]), 32'(ee[k]));
                     chk("pq", 32'({pv[k], qv[k]}), 32'({eg[k][0], el[k][0]}));
                     chk("bits_used", 32'(bu[k]), 32'(eb[k]));
                     sv[k] = snap(k);
                     if (hold == 0) begin ack[k] = 1'b1; acked[k] = 1; end
                  end else begin
                     chk("flags_low_busy", 32'({gtv[k], ltv[k], eqv[k]}), 32'd0);
                  end
               end else begin
                  chk("hold_stable", snap(k), sv[k]);
                  if (cyc == lat[k] + hold) begin ack[k] = 1'b1; acked[k] = 1; end
               end
            end
         end
      end
      st = 1'b0;
      for (int k = 0; k < 4; k++)
         if (!fin[k]) begin chk("timeout", 32'd0, 32'd1); ack[k] = 1'b0; end
   endtask

   initial begin
      rst = 1'b1; st = 1'b0; ack = '0; a8 = '0; b8 = '0; a4 = '0; b4 = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(rdy), 32'hF);
      chk("rst_valid", 32'(vld), 32'h0);
      chk("rst_pq", 32'({pv, qv}), 32'h0);
      chk("rst_flags", 32'({gtv, ltv, eqv}), 32'h0);
      chk("rst_bits", 32'({bu[0], bu[1], bu[2], bu[3]}), 32'h0);
      rst = 1'b0;

      run(8'hA5, 8'hA5, 4'h5, 4'h5, 0, -1, 8'h00, -1);
      // early-stop units finish at cycle 1 and see ack and start together
      run(8'h80, 8'h7F, 4'h8, 4'h7, 0, -1, 8'h00, 1);
      run(8'h10, 8'h11, 4'h0, 4'h1, 0, 2, 8'hFF, -1);
      // long equal scans: stray start mid-scan, then 5 cycles without ack
      run(8'hA5, 8'hA5, 4'hA, 4'hA, 5, -1, 8'h00, 3);

      @(negedge clk);
      a8 = 8'h00; b8 = 8'h00; a4 = 4'h0; b4 = 4'h0; st = 1'b1;
      @(negedge clk);
      st = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_ready", 32'(rdy), 32'hF);
      chk("midrst_valid", 32'(vld), 32'h0);
      chk("midrst_pq", 32'({pv, qv}), 32'h0);
      chk("midrst_bits", 32'({bu[0], bu[1], bu[2], bu[3]}), 32'h0);
      run(8'h01, 8'h02, 4'h1, 4'h2, 0, -1, 8'h00, -1);

      for (int i = 0; i < 256; i++) begin
         logic [7:0] ra, rb, iv;
         iv = 8'(i);
         ra = 8'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? (ra ^ (8'd1 << $urandom_range(0, 7))) : 8'($urandom);
         run(ra, rb, iv[7:4], iv[3:0], $urandom_range(0, 1), -1, 8'h00, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end
endmodule

// File: doc/comparador_serial_izq_der.md
Name: comparador_serial_izq_der

Overview:
Sequential controller that runs an unsigned magnitude comparison of two N-bit words MSB-first, one bit per clock. It uses the same P/Q state encoding as the left-to-right iterative comparator network: the initial cell evaluates bit N-1 and the iterative cell handles the remaining bits. It replaces N cascaded cells with a single state register, and adds a start/ready input handshake, a valid/ack output handshake and optional early termination.

Parameters:
N, 8, operand width in bits (N >= 1).
EARLY_STOP, 1, when 1 the scan ends on the first decided bit; when 0 all N bits are always scanned.

Ports:
clk  input  1  single system clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request a comparison; accepted only when ready=1.
A  input  N  operand A; sampled on the accepting edge only.
B  input  N  operand B; sampled on the accepting edge only.
ready  output  1  high only in IDLE.
valid  output  1  result available; held until ack.
ack  input  1  consumer acknowledge; effective only when valid=1.
P  output  1  state bit P (1 = A>B decided).
Q  output  1  state bit Q (1 = A<B decided).
gt  output  1  A>B; qualified by valid.
lt  output  1  A<B; qualified by valid.
eq  output  1  A==B; qualified by valid.
bits_used  output  $clog2(N+1)  number of bit positions examined, 1..N.

Behaviour:
- State encoding PQ: 00 = equal so far, 10 = A>B, 01 = A<B. 11 is illegal and must never be reached.
- Initial-cell function on bit N-1: P = a & ~b, Q = ~a & b.
- Iterative-cell function: if PQ != 00, PQ holds (absorbing). Otherwise PQ = {a&~b, ~a&b}.
- FSM states and transitions:
  - IDLE: ready=1. On start=1, latch A and B into internal registers, clear PQ and bits_used, go to INIT. Otherwise stay in IDLE.
  - INIT: apply the initial cell to bit N-1; set bits_used=1 and idx=N-2. Go to DONE if N==1, or if EARLY_STOP=1 and the new PQ != 00. Otherwise go to SCAN.
  - SCAN: apply the iterative cell to bit idx; increment bits_used. Go to DONE if idx==0, or if EARLY_STOP=1 and the new PQ != 00. Otherwise decrement idx.
  - DONE: valid=1. P, Q, gt=P, lt=Q, eq=~P&~Q and bits_used are held stable. On ack=1, go to IDLE.
- Latency: if start is accepted at edge k, valid rises after edge k+bits_used. Full scan means valid after edge k+N. With EARLY_STOP=1 and differing MSBs, valid rises after edge k+1.
- Changes on A or B after the accepting edge have no effect on the comparison in progress.
- start while ready=0 (INIT, SCAN or DONE) is ignored; no queuing.
- ack while valid=0 is ignored. ack and start asserted in the same DONE cycle: ack is taken, FSM goes to IDLE, start is dropped. The next start is accepted no earlier than the following cycle.
- Outputs outside DONE: gt, lt and eq are 0. P and Q show the running state. bits_used shows the running count.
- Reset, including mid-scan: state=IDLE, ready=1, valid=0, P=Q=0, gt=lt=eq=0, bits_used=0, internal operand registers cleared. Any operation in progress is abandoned with no valid pulse.

Test Plan:
- N=8, EARLY_STOP=1, A=8'hA5, B=8'hA5 -> valid 8 cycles after accept, eq=1, gt=lt=0, bits_used=8, PQ=00.
- N=8, EARLY_STOP=1, A=8'h80, B=8'h7F -> valid 1 cycle after accept, gt=1, bits_used=1. Same stimulus with EARLY_STOP=0 -> valid after 8 cycles, gt=1, bits_used=8.
- N=8, A=8'h10, B=8'h11 -> lt=1, bits_used=8. Change A to 8'hFF two cycles after accept -> result unchanged.
- Handshake: hold ack=0 for 5 cycles in DONE -> valid and all result outputs stable. Pulse start during SCAN -> ignored. Assert ack and start together -> IDLE, and the start is not accepted.
- Reset at the 4th SCAN cycle -> next cycle ready=1, valid=0, bits_used=0, P=Q=0. A fresh start of A=8'h01, B=8'h02 -> lt=1, bits_used=8.
- N=4, both EARLY_STOP values, all 256 A/B pairs back-to-back -> gt, lt and eq match unsigned compare. bits_used equals (index of the first differing bit from the MSB)+1, or 4 when the operands are equal or EARLY_STOP=0. PQ never equals 11.
